// File: rtl/uart_slave.sv
// Bus-side 8N1 UART peripheral: register file, holding-register transmitter and oversampling-free
// mid-bit receiver, both timed by a shared programmable baud divisor.
module uart_slave #(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  uart_addr,
  input  logic        uart_wen,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq_rx
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  logic [DIV_W-1:0] baud_div_q, baud_div_d;
  logic [DIV_W-1:0] eff_div, bit_reload, half_reload;

  state_e           tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             txd_q, txd_d;
  logic             tx_load;

  logic             rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d;
  state_e           rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_over_q, rx_over_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             rx_deliver, rx_stop_bad;

  logic             wr_tx, wr_stat, wr_baud;
  logic [2:0]       clr;
  logic             tx_busy;
  logic             wdata_unused;

  assign wdata_unused = ^uart_wdata;

  assign wr_tx   = uart_wen && (uart_addr == 2'd0);
  assign wr_stat = uart_wen && (uart_addr == 2'd1);
  assign wr_baud = uart_wen && (uart_addr == 2'd3);
  assign clr     = wr_stat ? uart_wdata[3:1] : 3'b000;

  // Divisors below 2 cannot give a meaningful mid-bit sample point, so they run as 2.
  assign eff_div     = (baud_div_q < DIV_W'(2)) ? DIV_W'(2) : baud_div_q;
  assign bit_reload  = eff_div - DIV_W'(1);
  assign half_reload = eff_div >> 1;

  assign baud_div_d = wr_baud ? uart_wdata[DIV_W-1:0] : baud_div_q;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = 1'b1;
    tx_load     = 1'b0;
    if (wr_tx && !hold_full_q) begin
      hold_d      = uart_wdata[7:0];
      hold_full_d = 1'b1;
    end
    case (tx_state_q)
      ST_IDLE: tx_load = hold_full_q;
      ST_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end else begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = bit_reload;
          tx_bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        txd_d = tx_shift_q[0];
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_cnt_d   = bit_reload;
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q != '0)   tx_cnt_d   = tx_cnt_q - DIV_W'(1);
        else if (hold_full_q) tx_load    = 1'b1;
        else                  tx_state_d = ST_IDLE;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Loading the shifter frees the holding register, letting the next write through.
    if (tx_load) begin
      tx_shift_d  = hold_q;
      hold_full_d = 1'b0;
      tx_state_d  = ST_START;
      tx_cnt_d    = bit_reload;
    end
  end

  always_comb begin
    rxd_meta_d  = uart_rxd;
    rxd_sync_d  = rxd_meta_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_deliver  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rxd_sync_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = half_reload;
        end
      end
      ST_START: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end else if (rxd_sync_q) begin
          rx_state_d = ST_IDLE;
        end else begin
          rx_state_d = ST_DATA;
          rx_cnt_d   = bit_reload;
          rx_bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end else begin
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = bit_reload;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end else begin
          rx_deliver  = 1'b1;
          rx_stop_bad = !rxd_sync_q;
          rx_state_d  = ST_IDLE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A delivery in the same cycle as a W1C of rx_valid wins and is not an overrun.
  assign rx_valid_d = (rx_valid_q & ~clr[0]) | rx_deliver;
  assign rx_over_d  = (rx_over_q & ~clr[1]) | (rx_deliver & rx_valid_q & ~clr[0]);
  assign rx_ferr_d  = (rx_ferr_q & ~clr[2]) | (rx_deliver & rx_stop_bad);
  assign rx_data_d  = rx_deliver ? rx_shift_q : rx_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div_q  <= DIV_W'(DIV_RESET);
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_over_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      baud_div_q  <= baud_div_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      rxd_meta_q  <= rxd_meta_d;
      rxd_sync_q  <= rxd_sync_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_over_q   <= rx_over_d;
      rx_ferr_q   <= rx_ferr_d;
    end
  end

  assign tx_busy    = hold_full_q | (tx_state_q != ST_IDLE);
  assign uart_ready = ~hold_full_q;
  assign uart_txd   = txd_q;
  assign irq_rx     = rx_valid_q;

  always_comb begin
    uart_rdata = 32'd0;
    case (uart_addr)
      2'd1:    uart_rdata = {27'd0, hold_full_q, rx_ferr_q, rx_over_q, rx_valid_q, tx_busy};
      2'd2:    uart_rdata = {24'd0, rx_data_q};
      2'd3:    uart_rdata = 32'(baud_div_q);
      default: uart_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_slave.sv
// Directed-plus-random bench for uart_slave: TX frames are decoded by mid-bit sampling and RX flags
// are predicted by a byte-level status model.
module tb_uart_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  uart_addr;
  logic        uart_wen;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        uart_txd;
  logic        uart_rxd;
  logic        irq_rx;

  always #5 clk = ~clk;

  uart_slave #(.DIV_W(16), .DIV_RESET(434)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_addr  (uart_addr),
    .uart_wen   (uart_wen),
    .uart_wdata (uart_wdata),
    .uart_rdata (uart_rdata),
    .uart_ready (uart_ready),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd),
    .irq_rx     (irq_rx)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ncur     = 0;
  int div      = 434;

  logic       m_valid, m_over, m_ferr;
  logic [7:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the n-th falling edge counted from the reference write.
  task automatic goto_neg(input int n);
    if (n > ncur) wait_negs(n - ncur);
    ncur = n;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (a == 2'd0 && !uart_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("bus_ready_timeout", 32'(uart_ready), 32'd1);
    uart_addr  = a;
    uart_wdata = d;
    uart_wen   = 1'b1;
    @(negedge clk);
    uart_wen   = 1'b0;
    uart_wdata = 32'd0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    uart_addr = a;
    #1;
    d = uart_rdata;
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic [31:0] exp_status();
    return {28'd0, m_ferr, m_over, m_valid, 1'b0};
  endfunction

  task automatic model_rx(input logic [7:0] b, input logic stopv);
    if (m_valid) m_over = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
    if (!stopv) m_ferr = 1'b1;
  endtask

  task automatic model_clear(input logic [31:0] w);
    if (w[1]) m_valid = 1'b0;
    if (w[2]) m_over  = 1'b0;
    if (w[3]) m_ferr  = 1'b0;
  endtask

  task automatic tx_capture(input int nbits, output logic [19:0] bits);
    bits = '0;
    for (int j = 0; j < nbits; j++) begin
      goto_neg(2 + j * div + div / 2);
      bits[j] = uart_txd;
    end
  endtask

  task automatic tx_one(input logic [7:0] b);
    logic [19:0] bits;
    logic [31:0] st, r;
    r = $urandom;
    bus_write(2'd0, {r[31:8], b});
    ncur = 0;
    check("tx_ready_low", 32'(uart_ready), 32'd0);
    goto_neg(1);
    check("tx_ready_back", 32'(uart_ready), 32'd1);
    check("tx_txd_idle", 32'(uart_txd), 32'd1);
    goto_neg(2);
    check("tx_txd_start", 32'(uart_txd), 32'd0);
    tx_capture(10, bits);
    check("tx_frame", 32'(bits[9:0]), 32'(frame(b)));
    if (10 * div > ncur) begin
      goto_neg(10 * div);
      read_reg(2'd1, st);
      check("tx_busy_last", 32'(st[0]), 32'd1);
    end
    goto_neg(10 * div + 1);
    read_reg(2'd1, st);
    check("tx_status_idle", st, 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopv);
    logic [9:0] f;
    f = {stopv, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_rxd = f[j];
      wait_negs(div);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] d;
    read_reg(2'd2, d);
    check({tag, "_rxdata"}, d, {24'd0, m_data});
    read_reg(2'd1, d);
    check({tag, "_status"}, d, exp_status());
    check({tag, "_irq"}, 32'(irq_rx), 32'(m_valid));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, w;
    logic [19:0] bits;
    logic [7:0]  b, b2;
    logic        stopv;

    rst_n = 1'b1; uart_wen = 1'b0; uart_addr = 2'd0; uart_wdata = 32'd0; uart_rxd = 1'b1;
    m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_ready", 32'(uart_ready), 32'd1);
    check("rst_irq", 32'(irq_rx), 32'd0);
    read_reg(2'd1, d); check("rst_status", d, 32'd0);
    read_reg(2'd3, d); check("rst_baud", d, 32'd434);
    read_reg(2'd0, d); check("rst_txdata_reads0", d, 32'd0);
    wait_negs(3);
    rst_n = 1'b1;
    wait_negs(2);

    // Transmit: 0xA5 then random bytes at divisor 4
    bus_write(2'd3, 32'd4); div = 4;
    read_reg(2'd3, d); check("baud_rw", d, 32'd4);
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      tx_one(b);
    end

    // Divisor 1 is stored as written but runs as 2
    bus_write(2'd3, 32'd1);
    read_reg(2'd3, d); check("baud_one_stored", d, 32'd1);
    div = 2;
    tx_one(8'($urandom));
    bus_write(2'd3, 32'd4); div = 4;

    // Back-to-back writes: second stalls one cycle, frames abut
    b = 8'h55; b2 = 8'h0F;
    bus_write(2'd0, {24'd0, b});
    ncur = 0;
    check("b2b_stall", 32'(uart_ready), 32'd0);
    bus_write(2'd0, {24'd0, b2});
    ncur = 2;
    check("b2b_start", 32'(uart_txd), 32'd0);
    tx_capture(20, bits);
    check("b2b_frames", 32'(bits), 32'({frame(b2), frame(b)}));
    goto_neg(20 * div);
    read_reg(2'd1, d); check("b2b_busy_last", 32'(d[0]), 32'd1);
    goto_neg(20 * div + 1);
    read_reg(2'd1, d); check("b2b_idle", d, 32'd0);

    // A write forced while the holding register is full is dropped
    b = 8'($urandom); b2 = 8'($urandom);
    bus_write(2'd0, {24'd0, b});
    ncur = 0;
    uart_addr = 2'd0; uart_wdata = {24'd0, b2}; uart_wen = 1'b1;
    @(negedge clk);
    uart_wen = 1'b0;
    ncur = 1;
    tx_capture(10, bits);
    check("drop_frame", 32'(bits[9:0]), 32'(frame(b)));
    goto_neg(10 * div + 1);
    read_reg(2'd1, d); check("drop_no_second", d, 32'd0);

    // Receive at divisor 8
    bus_write(2'd3, 32'd8); div = 8;
    send_rx(8'h3C, 1'b1); model_rx(8'h3C, 1'b1);
    wait_negs(2);
    check_rx("rx_3c");
    bus_write(2'd1, 32'h2); model_clear(32'h2);
    check_rx("rx_3c_clr");

    send_rx(8'h11, 1'b1); model_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1); model_rx(8'h22, 1'b1);
    wait_negs(2);
    check_rx("rx_overrun");
    bus_write(2'd1, 32'hE); model_clear(32'hE);
    check_rx("rx_clr_all");

    // Short low glitch is a false start
    uart_rxd = 1'b0;
    wait_negs(3);
    uart_rxd = 1'b1;
    wait_negs(3 * div);
    check_rx("rx_glitch");

    b = 8'($urandom);
    send_rx(b, 1'b0); model_rx(b, 1'b0);
    wait_negs(2 * div);
    check_rx("rx_frame_err");
    bus_write(2'd1, 32'hE); model_clear(32'hE);

    // W1C of rx_valid on the delivery edge: new byte wins, no overrun
    send_rx(8'h5A, 1'b1); model_rx(8'h5A, 1'b1);
    wait_negs(2 * div);
    b = 8'($urandom);
    fork
      send_rx(b, 1'b1);
      begin
        wait_negs(79);
        uart_addr = 2'd1; uart_wdata = 32'h2; uart_wen = 1'b1;
        @(negedge clk);
        uart_wen = 1'b0; uart_wdata = 32'd0;
      end
    join
    model_clear(32'h2); model_rx(b, 1'b1);
    wait_negs(2);
    check_rx("rx_set_wins");

    // Random frames with random stop bits and random W1C patterns
    for (int t = 0; t < 6; t++) begin
      b = 8'($urandom);
      stopv = ($urandom_range(0, 3) != 0);
      send_rx(b, stopv); model_rx(b, stopv);
      wait_negs(2 * div);
      check_rx("rx_rand");
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom;
        bus_write(2'd1, w); model_clear(w);
        check_rx("rx_rand_w1c");
      end
    end

    // Reset in the middle of a transmit frame
    bus_write(2'd3, 32'd4); div = 4;
    bus_write(2'd0, 32'd0);
    ncur = 0;
    goto_neg(2 + 5 * div + div / 2);
    check("rst_mid_pre_txd", 32'(uart_txd), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txd", 32'(uart_txd), 32'd1);
    check("rst_mid_ready", 32'(uart_ready), 32'd1);
    check("rst_mid_irq", 32'(irq_rx), 32'd0);
    read_reg(2'd3, d); check("rst_mid_baud", d, 32'd434);
    read_reg(2'd1, d); check("rst_mid_status", d, 32'd0);
    wait_negs(2);
    rst_n = 1'b1;
    wait_negs(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
